// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Central hazard sequencer for the 5-stage MIPS pipeline. It turns four
// hazard causes into one prioritized set of keep/bubble/flush controls for
// the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers:
//   - load-use hazard between the load in EX and the instruction in ID
//   - taken branch resolved in EX
//   - variable-latency data memory (access in MEM without ack)
//   - multi-cycle mult/div unit, tracked by an IDLE/BUSY FSM and a
//     down-counter
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   ID_rs_i, ID_rt_i         source register indices of the ID instruction
//   EX_rt_i, EX_mem_read_i   destination / load flag of the EX instruction
//   EX_branch_taken_i        branch in EX resolved taken
//   EX_muldiv_start_i        EX instruction starts the mult/div unit
//   ID_hilo_use_i            ID instruction reads or writes HI/LO
//   MEM_mem_access_i         valid load/store in MEM
//   MEM_ack_i                data memory completes the access this cycle
//   pc_keep_o .. MEM_WB_zero_o   pipeline register controls
//   muldiv_busy_o            mult/div unit occupied
//   muldiv_done_o            last busy cycle (HI/LO written at its end)
//   muldiv_cnt_o             remaining busy cycles minus 1 (0 when idle)
// ---------------------------------------------------------------------------
module pipeline_stall_controller #(
    parameter int R_WIDTH       = 5,
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_WIDTH     = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [R_WIDTH-1:0]   ID_rs_i,
    input  logic [R_WIDTH-1:0]   ID_rt_i,
    input  logic [R_WIDTH-1:0]   EX_rt_i,
    input  logic                 EX_mem_read_i,
    input  logic                 EX_branch_taken_i,
    input  logic                 EX_muldiv_start_i,
    input  logic                 ID_hilo_use_i,
    input  logic                 MEM_mem_access_i,
    input  logic                 MEM_ack_i,
    output logic                 pc_keep_o,
    output logic                 IF_ID_keep_o,
    output logic                 IF_ID_flush_o,
    output logic                 ID_EX_keep_o,
    output logic                 ID_EX_zero_o,
    output logic                 EX_MEM_keep_o,
    output logic                 MEM_WB_zero_o,
    output logic                 muldiv_busy_o,
    output logic                 muldiv_done_o,
    output logic [CNT_WIDTH-1:0] muldiv_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(MULDIV_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } muldiv_state_t;

    muldiv_state_t          state, state_nxt;
    logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;

    logic mem_wait;
    logic load_use;
    logic hilo_stall;
    logic busy;

    assign busy     = (state == BUSY);
    assign mem_wait = MEM_mem_access_i & ~MEM_ack_i;
    assign load_use = EX_mem_read_i & (EX_rt_i != '0) &
                      ((EX_rt_i == ID_rs_i) | (EX_rt_i == ID_rt_i));
    // A start still sitting in EX counts as busy: the ID instruction must
    // not touch HI/LO before the unit has even been launched.
    assign hilo_stall = ID_hilo_use_i & (busy | EX_muldiv_start_i);

    // Mult/div state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The unit runs independently of the pipeline: once launched it counts
    // through freezes and flushes. A start is only accepted when EX is not
    // frozen, otherwise the same instruction would be seen again next cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (EX_muldiv_start_i && !mem_wait) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            BUSY: begin
                // A start while busy is ignored; hilo_stall keeps it from
                // happening in a correct pipeline.
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Prioritized pipeline controls. A taken branch under mem_wait needs no
    // storage: EX is frozen, so the branch is still presented once the
    // memory acknowledges and the redirect happens then.
    always_comb begin
        pc_keep_o     = 1'b0;
        IF_ID_keep_o  = 1'b0;
        IF_ID_flush_o = 1'b0;
        ID_EX_keep_o  = 1'b0;
        ID_EX_zero_o  = 1'b0;
        EX_MEM_keep_o = 1'b0;
        MEM_WB_zero_o = 1'b0;
        if (rst_i) begin
            // everything stays low while reset is asserted
        end else if (mem_wait) begin
            pc_keep_o     = 1'b1;
            IF_ID_keep_o  = 1'b1;
            ID_EX_keep_o  = 1'b1;
            EX_MEM_keep_o = 1'b1;
            MEM_WB_zero_o = 1'b1;
        end else if (EX_branch_taken_i) begin
            // The ID instruction is squashed, so any stall it would need
            // is moot.
            IF_ID_flush_o = 1'b1;
            ID_EX_zero_o  = 1'b1;
        end else if (load_use || hilo_stall) begin
            pc_keep_o     = 1'b1;
            IF_ID_keep_o  = 1'b1;
            ID_EX_zero_o  = 1'b1;
        end
    end

    assign muldiv_busy_o = ~rst_i & busy;
    assign muldiv_done_o = ~rst_i & busy & (cnt == '0);
    assign muldiv_cnt_o  = rst_i ? '0 : cnt;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_controller
//
// Directed bench for pipeline_stall_controller. Two instances share every
// input: u_dut4 (MULDIV_CYCLES = 4) carries the control and short-latency
// checks, u_dut32 (default 32 cycles) carries the reset-mid-operation and
// long-latency counter checks.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_controller;

    localparam int RW = 5;
    localparam int CW = 6;

    // Control bundle order: pc_keep, IF_ID_keep, IF_ID_flush, ID_EX_keep,
    // ID_EX_zero, EX_MEM_keep, MEM_WB_zero
    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_FREEZE = 7'b1101011;
    localparam logic [6:0] C_REDIR  = 7'b0010100;
    localparam logic [6:0] C_STALL  = 7'b1100100;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] id_rs, id_rt, ex_rt;
    logic          ex_mem_read, ex_branch, ex_start, id_hilo, mem_access, mem_ack;

    logic          pk4, ik4, if4, ek4, ez4, mk4, wz4, busy4, done4;
    logic [CW-1:0] cnt4;
    logic          pk32, ik32, if32, ek32, ez32, mk32, wz32, busy32, done32;
    logic [CW-1:0] cnt32;
    logic [6:0]    ctl4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign ctl4 = {pk4, ik4, if4, ek4, ez4, mk4, wz4};

    pipeline_stall_controller #(.R_WIDTH(RW), .MULDIV_CYCLES(4), .CNT_WIDTH(CW)) u_dut4 (
        .clk_i(clk), .rst_i(rst),
        .ID_rs_i(id_rs), .ID_rt_i(id_rt), .EX_rt_i(ex_rt),
        .EX_mem_read_i(ex_mem_read), .EX_branch_taken_i(ex_branch),
        .EX_muldiv_start_i(ex_start), .ID_hilo_use_i(id_hilo),
        .MEM_mem_access_i(mem_access), .MEM_ack_i(mem_ack),
        .pc_keep_o(pk4), .IF_ID_keep_o(ik4), .IF_ID_flush_o(if4),
        .ID_EX_keep_o(ek4), .ID_EX_zero_o(ez4), .EX_MEM_keep_o(mk4),
        .MEM_WB_zero_o(wz4), .muldiv_busy_o(busy4), .muldiv_done_o(done4),
        .muldiv_cnt_o(cnt4)
    );

    pipeline_stall_controller #(.R_WIDTH(RW), .MULDIV_CYCLES(32), .CNT_WIDTH(CW)) u_dut32 (
        .clk_i(clk), .rst_i(rst),
        .ID_rs_i(id_rs), .ID_rt_i(id_rt), .EX_rt_i(ex_rt),
        .EX_mem_read_i(ex_mem_read), .EX_branch_taken_i(ex_branch),
        .EX_muldiv_start_i(ex_start), .ID_hilo_use_i(id_hilo),
        .MEM_mem_access_i(mem_access), .MEM_ack_i(mem_ack),
        .pc_keep_o(pk32), .IF_ID_keep_o(ik32), .IF_ID_flush_o(if32),
        .ID_EX_keep_o(ek32), .ID_EX_zero_o(ez32), .EX_MEM_keep_o(mk32),
        .MEM_WB_zero_o(wz32), .muldiv_busy_o(busy32), .muldiv_done_o(done32),
        .muldiv_cnt_o(cnt32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rt = '0;
        ex_mem_read = 1'b0; ex_branch = 1'b0; ex_start = 1'b0;
        id_hilo = 1'b0; mem_access = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();

        // ---- reset state, reset dominates a branch ----
        tick();
        chk("rst_ctl", 32'(ctl4), 32'(C_NONE));
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_done", 32'(done4), 32'd0);
        chk("rst_cnt", 32'(cnt4), 32'd0);
        ex_branch = 1'b1;
        #1 chk("rst_vs_branch", 32'(ctl4), 32'(C_NONE));
        ex_branch = 1'b0;
        rst = 1'b0;
        tick();

        // ---- load-use ----
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_rt = 5'd3;
        #1 chk("load_use_rs", 32'(ctl4), 32'(C_STALL));
        tick();
        ex_mem_read = 1'b0;   // load moved on, bubble now in EX
        #1 chk("load_use_1cyc", 32'(ctl4), 32'(C_NONE));
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1 chk("load_use_r0", 32'(ctl4), 32'(C_NONE));
        ex_rt = 5'd5; id_rs = 5'd1; id_rt = 5'd5;
        #1 chk("load_use_rt", 32'(ctl4), 32'(C_STALL));
        ex_mem_read = 1'b0;
        #1 chk("no_load_match", 32'(ctl4), 32'(C_NONE));

        // ---- branch beats load-use ----
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; ex_branch = 1'b1;
        #1 chk("branch_vs_stall", 32'(ctl4), 32'(C_REDIR));
        tick();

        // ---- memory wait with a pending branch ----
        mem_access = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("mem_wait_%0d", i), 32'(ctl4), 32'(C_FREEZE));
            tick();
        end
        mem_ack = 1'b1;
        #1 chk("branch_after_ack", 32'(ctl4), 32'(C_REDIR));
        tick();
        clear_inputs();
        #1 chk("idle_ctl", 32'(ctl4), 32'(C_NONE));
        id_hilo = 1'b1;
        #1 chk("hilo_idle", 32'(ctl4), 32'(C_NONE));
        id_hilo = 1'b0;

        // ---- start under freeze is held off ----
        mem_access = 1'b1; mem_ack = 1'b0; ex_start = 1'b1;
        #1 chk("frz_start_ctl", 32'(ctl4), 32'(C_FREEZE));
        tick();
        chk("frz_start_busy_a", 32'(busy4), 32'd0);
        tick();
        chk("frz_start_busy_b", 32'(busy4), 32'd0);
        mem_ack = 1'b1;
        #1 chk("frz_ack_ctl", 32'(ctl4), 32'(C_NONE));
        tick();
        chk("frz_start_busy_c", 32'(busy4), 32'd1);
        chk("frz_start_cnt", 32'(cnt4), 32'd3);
        clear_inputs();

        // ---- long unit counts down; reset at cnt = 10 ----
        for (int j = 0; j < 21; j++) begin
            chk($sformatf("cnt32_%0d", j), 32'(cnt32), 32'(31 - j));
            tick();
        end
        chk("cnt32_at10", 32'(cnt32), 32'd10);
        chk("busy4_back_idle", 32'(busy4), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy32), 32'd0);
        chk("rst_mid_done", 32'(done32), 32'd0);
        chk("rst_mid_cnt", 32'(cnt32), 32'd0);
        ex_start = 1'b1; id_hilo = 1'b1;
        tick();
        rst = 1'b0;
        chk("after_rst_idle", 32'(busy32), 32'd0);
        #1 chk("hilo_vs_start", 32'(ctl4), 32'(C_STALL));

        // ---- full latency from edge T (both instances start together) ----
        tick();
        ex_start = 1'b0;
        for (int k = 0; k < 33; k++) begin
            if (k == 1) ex_start = 1'b1;   // illegal restart must be ignored
            if (k == 2) ex_start = 1'b0;
            #1;
            if (k < 4) begin
                chk($sformatf("busy4_%0d", k), 32'(busy4), 32'd1);
                chk($sformatf("cnt4_%0d", k), 32'(cnt4), 32'(3 - k));
                chk($sformatf("done4_%0d", k), 32'(done4), 32'(k == 3));
                chk($sformatf("stall4_%0d", k), 32'(ctl4), 32'(C_STALL));
            end else if (k == 4) begin
                chk("busy4_end", 32'(busy4), 32'd0);
                chk("cnt4_end", 32'(cnt4), 32'd0);
                chk("mflo_proceeds", 32'(ctl4), 32'(C_NONE));
                id_hilo = 1'b0;
            end
            if (k < 32) begin
                chk($sformatf("busy32_%0d", k), 32'(busy32), 32'd1);
                chk($sformatf("cnt32l_%0d", k), 32'(cnt32), 32'(31 - k));
                chk($sformatf("done32_%0d", k), 32'(done32), 32'(k == 31));
            end else begin
                chk("busy32_end", 32'(busy32), 32'd0);
                chk("done32_end", 32'(done32), 32'd0);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
